// File: rtl/octree_anchor_updater.sv
// octree_anchor_updater
// Handles the controller's add/delete requests. Each request reads one octree
// node word {child_mask[7:0], anchor_cnt}, updates the addressed child slot and
// the anchor counter, writes the word back, and then returns a done pulse.
// Optional build macro: OCTREE_UPD_FREE_EN. When it is defined, a delete that
// empties the child mask writes an all-zero word and pulses node_free.
module octree_anchor_updater #(
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 8,
   parameter int RD_LAT = 1,
   localparam int DATA_W = 8 + CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              add_anchor,
   input  logic              del_anchor,
   input  logic [ADDR_W-1:0] node_addr,
   input  logic [2:0]        child_idx,
   output logic              add_done,
   output logic              del_done,
   output logic              upd_err,
   output logic              busy,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              node_free
);

   localparam int LAT_W = $clog2(RD_LAT + 1);

   typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

   state_t              r_state;
   logic [LAT_W-1:0]    r_waitCnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [2:0]          r_idx;
   logic                r_isDel;
   logic                r_addDone;
   logic                r_delDone;
   logic                r_updErr;
   logic                r_busy;
   logic                r_memReq;
   logic                r_memWe;
   logic [ADDR_W-1:0]   r_memAddr;
   logic [DATA_W-1:0]   r_memWdata;

   state_t              w_nextState;
   logic [LAT_W-1:0]    w_nextWaitCnt;
   logic                w_accept;
   logic                w_addDone;
   logic                w_delDone;
   logic                w_updErr;
   logic                w_memReq;
   logic                w_memWe;
   logic [ADDR_W-1:0]   w_memAddr;
   logic [DATA_W-1:0]   w_memWdata;

   logic [7:0]          w_oldMask;
   logic [CNT_W-1:0]    w_oldCnt;
   logic [7:0]          w_childBit;
   logic                w_slotUsed;
   logic                w_legal;
   logic [7:0]          w_newMask;
   logic [CNT_W-1:0]    w_newCnt;
   logic [DATA_W-1:0]   w_newWord;

   // Apply the add/delete rule to the word arriving from SRAM
   always_comb begin
      w_oldMask  = mem_rdata[DATA_W-1:CNT_W];
      w_oldCnt   = mem_rdata[CNT_W-1:0];
      w_childBit = 8'(1) << r_idx;
      w_slotUsed = |(w_oldMask & w_childBit);
      w_legal    = r_isDel ? w_slotUsed : !w_slotUsed;
      if (r_isDel) begin
         w_newMask = w_oldMask & ~w_childBit;
         w_newCnt  = (w_oldCnt == '0) ? '0 : (w_oldCnt - CNT_W'(1));
      end else begin
         w_newMask = w_oldMask | w_childBit;
         w_newCnt  = (&w_oldCnt) ? w_oldCnt : (w_oldCnt + CNT_W'(1));
      end
      w_newWord = {w_newMask, w_newCnt};
`ifdef OCTREE_UPD_FREE_EN
      if (r_isDel && (w_newMask == 8'h00)) begin
         w_newWord = '0;
      end
`endif
   end

   // Next state and next values of all registered outputs
   always_comb begin
      w_nextState   = r_state;
      w_nextWaitCnt = r_waitCnt;
      w_accept      = 1'b0;
      w_addDone     = 1'b0;
      w_delDone     = 1'b0;
      w_updErr      = 1'b0;
      w_memReq      = 1'b0;
      w_memWe       = 1'b0;
      w_memAddr     = r_memAddr;
      w_memWdata    = r_memWdata;
      case (r_state)
         IDLE: begin
            if (add_anchor ^ del_anchor) begin
               w_accept    = 1'b1;
               w_nextState = READ;
               w_memReq    = 1'b1;
               w_memAddr   = node_addr;
            end else if (add_anchor && del_anchor) begin
               w_updErr = 1'b1;
            end
         end
         READ: begin
            w_nextState   = WAIT;
            w_nextWaitCnt = LAT_W'(RD_LAT);
         end
         WAIT: begin
            if (r_waitCnt == LAT_W'(1)) begin
               if (w_legal) begin
                  w_nextState = WRITE;
                  w_memReq    = 1'b1;
                  w_memWe     = 1'b1;
                  w_memAddr   = r_addr;
                  w_memWdata  = w_newWord;
               end else begin
                  w_nextState = DONE;
                  w_addDone   = !r_isDel;
                  w_delDone   = r_isDel;
                  w_updErr    = 1'b1;
               end
            end else begin
               w_nextWaitCnt = r_waitCnt - LAT_W'(1);
            end
         end
         WRITE: begin
            w_nextState = DONE;
            w_addDone   = !r_isDel;
            w_delDone   = r_isDel;
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State register, command latch and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_waitCnt  <= '0;
         r_addr     <= '0;
         r_idx      <= '0;
         r_isDel    <= 1'b0;
         r_addDone  <= 1'b0;
         r_delDone  <= 1'b0;
         r_updErr   <= 1'b0;
         r_busy     <= 1'b0;
         r_memReq   <= 1'b0;
         r_memWe    <= 1'b0;
         r_memAddr  <= '0;
         r_memWdata <= '0;
      end else begin
         r_state    <= w_nextState;
         r_waitCnt  <= w_nextWaitCnt;
         if (w_accept) begin
            r_addr  <= node_addr;
            r_idx   <= child_idx;
            r_isDel <= del_anchor;
         end
         r_addDone  <= w_addDone;
         r_delDone  <= w_delDone;
         r_updErr   <= w_updErr;
         r_busy     <= (w_nextState != IDLE);
         r_memReq   <= w_memReq;
         r_memWe    <= w_memWe;
         r_memAddr  <= w_memAddr;
         r_memWdata <= w_memWdata;
      end
   end

`ifdef OCTREE_UPD_FREE_EN
   logic r_nodeFree;
   logic w_nodeFree;

   // A delete can only reach WRITE with an empty mask when it freed the node
   always_comb begin
      w_nodeFree = (r_state == WRITE) && r_isDel && (r_memWdata[DATA_W-1:CNT_W] == 8'h00);
   end

   // node_free pulses together with del_done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_nodeFree <= 1'b0;
      end else begin
         r_nodeFree <= w_nodeFree;
      end
   end

   assign node_free = r_nodeFree;
`else
   assign node_free = 1'b0;
`endif

   assign add_done  = r_addDone;
   assign del_done  = r_delDone;
   assign upd_err   = r_updErr;
   assign busy      = r_busy;
   assign mem_req   = r_memReq;
   assign mem_we    = r_memWe;
   assign mem_addr  = r_memAddr;
   assign mem_wdata = r_memWdata;

endmodule

// File: tb/tb_octree_anchor_updater.sv
// Testbench for octree_anchor_updater: a RD_LAT=1 instance backed by an SRAM
// model, and a RD_LAT=3 instance with bench-driven read data for reset and
// latency sequences.
module tb_octree_anchor_updater;

`ifdef OCTREE_UPD_FREE_EN
   localparam bit FREE_EN_B = 1'b1;
`else
   localparam bit FREE_EN_B = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        addAnchor = 1'b0;
   logic        delAnchor = 1'b0;
   logic [11:0] nodeAddr = '0;
   logic [2:0]  childIdx = '0;
   logic        addDone, delDone, updErr, busy, memReq, memWe, nodeFree;
   logic [11:0] memAddr;
   logic [15:0] memWdata;
   logic [15:0] memRdata = '0;

   logic        rst3 = 1'b1;
   logic        add3 = 1'b0;
   logic        del3 = 1'b0;
   logic [11:0] addr3 = '0;
   logic [2:0]  idx3 = '0;
   logic        addDone3, delDone3, updErr3, busy3, memReq3, memWe3, nodeFree3;
   logic [11:0] memAddr3;
   logic [15:0] memWdata3;
   logic [15:0] memRdata3 = 16'h02FF;

   logic        pokeEn = 1'b0;
   logic [11:0] pokeAddr = '0;
   logic [15:0] pokeData = '0;
   logic [15:0] sram [0:4095];
   logic [15:0] refMem [0:4095];

   int checks = 0;
   int errors = 0;

   octree_anchor_updater #(.ADDR_W(12), .CNT_W(8), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .add_anchor(addAnchor), .del_anchor(delAnchor),
      .node_addr(nodeAddr), .child_idx(childIdx), .add_done(addDone),
      .del_done(delDone), .upd_err(updErr), .busy(busy), .mem_req(memReq),
      .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
      .mem_rdata(memRdata), .node_free(nodeFree));

   octree_anchor_updater #(.ADDR_W(12), .CNT_W(8), .RD_LAT(3)) dut3 (
      .clk(clk), .rst(rst3), .add_anchor(add3), .del_anchor(del3),
      .node_addr(addr3), .child_idx(idx3), .add_done(addDone3),
      .del_done(delDone3), .upd_err(updErr3), .busy(busy3), .mem_req(memReq3),
      .mem_we(memWe3), .mem_addr(memAddr3), .mem_wdata(memWdata3),
      .mem_rdata(memRdata3), .node_free(nodeFree3));

   // Single-port SRAM with one cycle of read latency, plus a preload port
   always @(posedge clk) begin
      if (pokeEn) sram[pokeAddr] <= pokeData;
      if (memReq && memWe) sram[memAddr] <= memWdata;
      if (memReq && !memWe) memRdata <= sram[memAddr];
   end

   typedef struct {
      int rdCnt; int rdK; int wrCnt; int wrK; int wrAddr; int wrData;
      int addCnt; int delCnt; int doneK; int errCnt; int errK;
      int freeCnt; int freeK; int busyCyc;
   } obs_t;

   typedef struct {
      string       name;
      int          op;
      logic [11:0] addr;
      logic [2:0]  idx;
      logic [15:0] stored;
      bit          legal;
      logic [15:0] word;
      bit          freeIfEn;
      int          injectK;
   } vec_t;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   task automatic pokeWord(input logic [11:0] a, input logic [15:0] d);
      @(negedge clk);
      pokeEn = 1'b1; pokeAddr = a; pokeData = d;
      refMem[a] = d;
      @(negedge clk);
      pokeEn = 1'b0;
   endtask

   // Reference rule: op 0 = add, 1 = delete, computed with plain integers
   function automatic void refUpdate(input int op, input logic [15:0] old, input int idx,
                                     output bit legal, output logic [15:0] nw, output bit free);
      int mask = int'(old[15:8]);
      int cnt  = int'(old[7:0]);
      int slot = (mask / (1 << idx)) % 2;
      if (op == 0) begin
         legal = (slot == 0);
         mask  = mask + (1 << idx);
         cnt   = (cnt == 255) ? 255 : cnt + 1;
      end else begin
         legal = (slot == 1);
         mask  = mask - (1 << idx);
         cnt   = (cnt > 0) ? cnt - 1 : 0;
      end
      free = FREE_EN_B && (op == 1) && legal && (mask == 0);
      if (free) cnt = 0;
      nw = 16'(mask * 256 + cnt);
   endfunction

   // op: 0 add, 1 delete, 2 both at once; injectK re-pulses add in that cycle
   task automatic applyStimulus(input int op, input logic [11:0] a, input logic [2:0] idx,
                                input int injectK, output obs_t o);
      o = '{default: 0};
      @(negedge clk);
      addAnchor = (op == 0 || op == 2);
      delAnchor = (op == 1 || op == 2);
      nodeAddr = a; childIdx = idx;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         addAnchor = (k == injectK);
         delAnchor = 1'b0;
         if (memReq && !memWe) begin o.rdCnt++; o.rdK = k; end
         if (memReq && memWe) begin
            o.wrCnt++; o.wrK = k; o.wrAddr = int'(memAddr); o.wrData = int'(memWdata);
         end
         if (addDone) begin o.addCnt++; o.doneK = k; end
         if (delDone) begin o.delCnt++; o.doneK = k; end
         if (updErr) begin o.errCnt++; o.errK = k; end
         if (nodeFree) begin o.freeCnt++; o.freeK = k; end
         if (busy) o.busyCyc++;
      end
   endtask

   task automatic checkTxn(input string n, input int op, input logic [11:0] a, input bit legal,
                           input logic [15:0] word, input bit expFree, input obs_t o);
      if (op == 2) begin
         checkOutput({n, " rd_cnt"}, o.rdCnt, 0);
         checkOutput({n, " wr_cnt"}, o.wrCnt, 0);
         checkOutput({n, " done_cnt"}, o.addCnt + o.delCnt, 0);
         checkOutput({n, " err_cnt"}, o.errCnt, 1);
         checkOutput({n, " err_k"}, o.errK, 1);
         checkOutput({n, " busy_cyc"}, o.busyCyc, 0);
      end else begin
         checkOutput({n, " rd_cnt"}, o.rdCnt, 1);
         checkOutput({n, " rd_k"}, o.rdK, 1);
         checkOutput({n, " done_kind"}, (op == 1) ? o.delCnt : o.addCnt, 1);
         checkOutput({n, " other_done"}, (op == 1) ? o.addCnt : o.delCnt, 0);
         checkOutput({n, " free_cnt"}, o.freeCnt, int'(expFree));
         if (legal) begin
            checkOutput({n, " wr_cnt"}, o.wrCnt, 1);
            checkOutput({n, " wr_k"}, o.wrK, 3);
            checkOutput({n, " wr_addr"}, o.wrAddr, int'(a));
            checkOutput({n, " wr_data"}, o.wrData, int'(word));
            checkOutput({n, " done_k"}, o.doneK, 4);
            checkOutput({n, " err_cnt"}, o.errCnt, 0);
            checkOutput({n, " busy_cyc"}, o.busyCyc, 4);
            if (expFree) checkOutput({n, " free_k"}, o.freeK, 4);
         end else begin
            checkOutput({n, " wr_cnt"}, o.wrCnt, 0);
            checkOutput({n, " done_k"}, o.doneK, 3);
            checkOutput({n, " err_cnt"}, o.errCnt, 1);
            checkOutput({n, " err_k"}, o.errK, 3);
            checkOutput({n, " busy_cyc"}, o.busyCyc, 3);
         end
      end
   endtask

   initial begin
      vec_t        vecs [9];
      obs_t        o;
      bit          legal, free;
      logic [15:0] nw;
      int          op, idx, sel, reqSeen, weSeen;
      logic [11:0] a;

      vecs[0] = '{"add_empty",   0, 12'h010, 3'd3, 16'h0000, 1'b1, 16'h0801, 1'b0, 0};
      vecs[1] = '{"del_keep",    1, 12'h020, 3'd2, 16'h0C05, 1'b1, 16'h0804, 1'b0, 0};
      vecs[2] = '{"add_illegal", 0, 12'h030, 3'd3, 16'h0801, 1'b0, 16'h0000, 1'b0, 0};
      vecs[3] = '{"add_sat",     0, 12'h040, 3'd0, 16'h00FF, 1'b1, 16'h01FF, 1'b0, 0};
      vecs[4] = '{"del_floor",   1, 12'h050, 3'd0, 16'h0100, 1'b1, 16'h0000, 1'b1, 0};
      vecs[5] = '{"both",        2, 12'h060, 3'd0, 16'h0F0F, 1'b0, 16'h0000, 1'b0, 0};
      vecs[6] = '{"del_last",    1, 12'h070, 3'd7, 16'h8001, 1'b1, 16'h0000, 1'b1, 0};
      vecs[7] = '{"del_illegal", 1, 12'h080, 3'd5, 16'h0003, 1'b0, 16'h0000, 1'b0, 0};
      vecs[8] = '{"add_inject",  0, 12'h090, 3'd1, 16'h0000, 1'b1, 16'h0201, 1'b0, 2};

      repeat (3) @(negedge clk);
      checkOutput("reset mem_req", int'(memReq), 0);
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset done_err", int'({addDone, delDone, updErr}), 0);
      checkOutput("reset mem_addr", int'(memAddr), 0);
      checkOutput("reset mem_wdata", int'(memWdata), 0);
      checkOutput("reset mem_we_free", int'({memWe, nodeFree}), 0);
      rst = 1'b0;
      rst3 = 1'b0;

      for (int i = 0; i < 9; i++) begin
         pokeWord(vecs[i].addr, vecs[i].stored);
         applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].idx, vecs[i].injectK, o);
         checkTxn(vecs[i].name, vecs[i].op, vecs[i].addr, vecs[i].legal, vecs[i].word,
                  vecs[i].freeIfEn && FREE_EN_B, o);
      end

      for (int i = 0; i < 16; i++) begin
         pokeWord(12'h100 + 12'(i), 16'($urandom));
      end
      pokeWord(12'h10F, 16'h0201);
      for (int t = 0; t < 40; t++) begin
         sel = $urandom_range(0, 9);
         op  = (sel == 0) ? 2 : (sel % 2);
         idx = $urandom_range(0, 7);
         a   = 12'h100 + 12'($urandom_range(0, 15));
         legal = 1'b0; free = 1'b0; nw = '0;
         if (op != 2) refUpdate(op, refMem[a], idx, legal, nw, free);
         applyStimulus(op, a, 3'(idx), 0, o);
         checkTxn($sformatf("rand%0d", t), op, a, legal, nw, free, o);
         if (op != 2 && legal) refMem[a] = nw;
      end

      // RD_LAT=3 instance: reset while waiting on the read must abort quietly
      @(negedge clk);
      add3 = 1'b1; addr3 = 12'h123; idx3 = 3'd1;
      weSeen = 0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         add3 = 1'b0;
         if (memReq3 && memWe3) weSeen++;
      end
      checkOutput("lat3 busy_before_rst", int'(busy3), 1);
      rst3 = 1'b1;
      #1;
      checkOutput("lat3 rst mem_req", int'(memReq3), 0);
      checkOutput("lat3 rst busy", int'(busy3), 0);
      checkOutput("lat3 rst mem_addr", int'(memAddr3), 0);
      repeat (2) @(negedge clk);
      rst3 = 1'b0;
      reqSeen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (memReq3) reqSeen++;
         if (memReq3 && memWe3) weSeen++;
      end
      checkOutput("lat3 no_write", weSeen, 0);
      checkOutput("lat3 no_req_after_rst", reqSeen, 0);

      // RD_LAT=3 full add: data is only correct in the last wait cycle
      @(negedge clk);
      add3 = 1'b1; addr3 = 12'h124; idx3 = 3'd1;
      o = '{default: 0};
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         add3 = 1'b0;
         if (memReq3 && !memWe3) begin o.rdCnt++; o.rdK = k; end
         if (memReq3 && memWe3) begin o.wrCnt++; o.wrK = k; o.wrData = int'(memWdata3); end
         if (addDone3) begin o.addCnt++; o.doneK = k; end
         if (updErr3) o.errCnt++;
         memRdata3 = (k == 4) ? 16'h0000 : 16'h02FF;
      end
      checkOutput("lat3 rd_k", o.rdK, 1);
      checkOutput("lat3 wr_cnt", o.wrCnt, 1);
      checkOutput("lat3 wr_k", o.wrK, 5);
      checkOutput("lat3 wr_data", o.wrData, 16'h0201);
      checkOutput("lat3 done_k", o.doneK, 6);
      checkOutput("lat3 done_cnt", o.addCnt, 1);
      checkOutput("lat3 err_cnt", o.errCnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
